mul2x2_seq_ctrl: RTL and testbench
==================================

Name: mul2x2_seq_ctrl

Overview:
Sequencer that computes a WIDTH x WIDTH unsigned product by time-sharing one external combinational 2x2-bit multiplier. The multiplier has inputs a,b,c,d and outputs f3..f0, computing {f3,f2,f1,f0} = {a,b} * {c,d}. The controller splits both operands into 2-bit digits and drives every digit pair into the multiplier, one pair per cycle. It accumulates the shifted partial products and reports the result with a start/busy/done handshake. It sits between a requesting datapath and the existing 2x2 multiplier instance.

Parameters:
- WIDTH, 8, operand width in bits. Must be even and >= 2; other values are unsupported.
- D (derived), WIDTH/2, number of 2-bit digits per operand. Not overridable.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- start  input  1  request; accepted only in IDLE.
- op_x  input  WIDTH  multiplicand, sampled when start is accepted.
- op_y  input  WIDTH  multiplier, sampled when start is accepted.
- busy  output  1  high while an operation is in progress (RUN and DONE).
- done  output  1  one-cycle pulse; product is valid and new.
- product  output  2*WIDTH  op_x*op_y; holds until the next completion.
- mul_a  output  1  to the 2x2 multiplier: MSB of the x digit.
- mul_b  output  1  to the 2x2 multiplier: LSB of the x digit.
- mul_c  output  1  to the 2x2 multiplier: MSB of the y digit.
- mul_d  output  1  to the 2x2 multiplier: LSB of the y digit.
- mul_f  input  4  {f3,f2,f1,f0} from the multiplier; combinational, valid in the same cycle.

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-low; all state updates on the rising edge of clk.
- Reset values (rst_n=0 at an edge):
  - state=IDLE, busy=0, done=0, product=0.
  - Accumulator and digit indices i, j cleared.
  - mul_a..mul_d=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0, mul_* driven 0.
  - When start=1 at an edge: latch op_x and op_y, clear acc, set i=0, j=0, and go to RUN.
- RUN (busy=1):
  - {mul_a,mul_b} = x[2i+1:2i] and {mul_c,mul_d} = y[2j+1:2j].
  - Each edge: acc <= acc + (mul_f << 2*(i+j)). The add is exact at 2*WIDTH bits and cannot overflow.
  - Index order: j advances fastest. When j=D-1, j wraps to 0 and i increments.
  - On the edge that processes (i=D-1, j=D-1): product <= acc + last term, and go to DONE.
- DONE:
  - busy=1, done=1 for exactly one cycle, mul_* driven 0.
  - Next edge returns to IDLE unconditionally.
- Latency: start accepted at edge E0 → RUN for D*D cycles → product updated and done high in the cycle after edge E(D*D).
  - For WIDTH=8: 16 RUN cycles; done high in the cycle following the 16th edge after E0.
  - For WIDTH=2: 1 RUN cycle.
- start while busy=1 (RUN or DONE) is ignored: no re-latch, no queuing.
  - Earliest restart is start=1 in the first IDLE cycle after done.
- op_x/op_y changes after acceptance have no effect on the running operation.
- product is not cleared at start; it keeps the previous result until the next done.
- Reset mid-operation aborts the operation with no done pulse. All outputs take their reset values at that edge, including product=0.
- mul_f is assumed to settle within one cycle; mul_* change only on clk edges.

Test Plan:
- WIDTH=2, op_x=3, op_y=3, start pulse → one RUN cycle with mul_a..d=1111, mul_f=9; next cycle done=1, product=9, busy=1; following cycle busy=0.
- WIDTH=8, op_x=0xFF, op_y=0xFF → 16 RUN cycles, each with mul_f=9; done exactly 17 cycles after the start edge; product=0xFE01.
- WIDTH=8, op_x=0x5A, op_y=0x3C → product=0x1518 (5400).
  - Monitor the digit order: first cycle x digit 2 (10b), y digit 0 (00b).
  - Second cycle y digit 3 (11b), x digit unchanged.
- Start held high continuously with op_x=0x5A, op_y=0x3C, then op_x=7, op_y=6 presented mid-run → first result 0x1518 is unaffected by the mid-run operands.
  - Second operation starts only in the IDLE cycle after done; it latches the operands present at that edge; product=42 (0x002A).
- rst_n=0 for one edge during RUN cycle 5 → busy=0, done=0, product=0 and no done pulse afterwards.
  - A new start with op_x=2, op_y=3 then completes normally with product=6.
- Exhaustive WIDTH=4 sweep of all 256 operand pairs against a reference multiply → every product matches and each done is a single-cycle pulse.

Source files
------------

// File: rtl/mul2x2_seq_ctrl.sv
// rtl/mul2x2_seq_ctrl.sv - WIDTH x WIDTH unsigned multiply sequenced over one external 2x2 multiplier
//
// Purpose: splits both operands into 2-bit digits and feeds every digit pair
// to a shared combinational 2x2 multiplier, one pair per cycle. It adds up the
// shifted partial products and reports the result with a start/busy/done handshake.
//
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   start, op_x, op_y   request and operands; operands are latched when start is accepted
//   busy, done, product status and result; product holds until the next completion
//   mul_a..mul_d        digit pair driven to the 2x2 multiplier ({a,b} = x digit, {c,d} = y digit)
//   mul_f               4-bit product returned by the 2x2 multiplier in the same cycle
module mul2x2_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_x,
  input  logic [WIDTH-1:0]   op_y,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               mul_a,
  output logic               mul_b,
  output logic               mul_c,
  output logic               mul_d,
  input  logic [3:0]         mul_f
);

  localparam int D  = WIDTH / 2;
  localparam int IW = (D > 1) ? $clog2(D) : 1;
  localparam int PW = 2 * WIDTH;
  localparam logic [IW-1:0] LAST = IW'(D - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [PW-1:0]   r_acc;
  logic [IW-1:0]   r_i;
  logic [IW-1:0]   r_j;

  logic [IW+1:0]   w_shamt;
  logic [PW-1:0]   w_term;
  logic [PW-1:0]   w_sum;
  logic            w_last;
  logic [IW-1:0]   w_i_nxt;
  logic [IW-1:0]   w_j_nxt;
  logic [WIDTH-1:0] w_x_sh;
  logic [WIDTH-1:0] w_y_sh;

  // Partial product of digit pair (i,j) carries weight 4^(i+j).
  always_comb begin
    w_shamt = {1'b0, r_i, 1'b0} + {1'b0, r_j, 1'b0};
    w_term  = PW'(mul_f) << w_shamt;
    w_sum   = r_acc + w_term;
    w_last  = (r_i == LAST) && (r_j == LAST);
    // j is the fast index; it wraps to 0 and carries into i.
    if (r_j == LAST) begin
      w_j_nxt = '0;
      w_i_nxt = r_i + IW'(1);
    end else begin
      w_j_nxt = r_j + IW'(1);
      w_i_nxt = r_i;
    end
    // Digit pair for the next RUN cycle; the mul_* lines are registered, so
    // they are loaded one edge ahead with the indices that cycle will use.
    w_x_sh = r_x >> {w_i_nxt, 1'b0};
    w_y_sh = r_y >> {w_j_nxt, 1'b0};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_acc   <= '0;
      r_i     <= '0;
      r_j     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      mul_a   <= 1'b0;
      mul_b   <= 1'b0;
      mul_c   <= 1'b0;
      mul_d   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            r_x     <= op_x;
            r_y     <= op_y;
            r_acc   <= '0;
            r_i     <= '0;
            r_j     <= '0;
            {mul_a, mul_b} <= op_x[1:0];
            {mul_c, mul_d} <= op_y[1:0];
            busy    <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc <= w_sum;
          if (w_last) begin
            product <= w_sum;
            done    <= 1'b1;
            r_i     <= '0;
            r_j     <= '0;
            mul_a   <= 1'b0;
            mul_b   <= 1'b0;
            mul_c   <= 1'b0;
            mul_d   <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_i <= w_i_nxt;
            r_j <= w_j_nxt;
            {mul_a, mul_b} <= w_x_sh[1:0];
            {mul_c, mul_d} <= w_y_sh[1:0];
          end
        end
        S_DONE: begin
          // start is ignored here; the earliest restart is the following IDLE cycle.
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          mul_a   <= 1'b0;
          mul_b   <= 1'b0;
          mul_c   <= 1'b0;
          mul_d   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul2x2_seq_ctrl.sv
// tb/tb_mul2x2_seq_ctrl.sv - scoreboard bench for mul2x2_seq_ctrl at WIDTH 8, 4 and 2
module tb_mul2x2_seq_ctrl;

  typedef struct {
    logic [15:0] p;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_n;
  logic rst8_req;
  logic rst8_n;
  assign rst8_n = rst_n & ~rst8_req;

  logic       st [3];
  logic [7:0] ox [3];
  logic [7:0] oy [3];

  logic        busy8, done8, a8, b8, c8, d8;
  logic [15:0] p8;
  logic [3:0]  f8;
  logic        busy4, done4, a4, b4, c4, d4;
  logic [7:0]  p4;
  logic [3:0]  f4;
  logic        busy2, done2, a2, b2, c2, d2;
  logic [3:0]  p2;
  logic [3:0]  f2;

  // External 2x2 multipliers
  assign f8 = {2'b00, a8, b8} * {2'b00, c8, d8};
  assign f4 = {2'b00, a4, b4} * {2'b00, c4, d4};
  assign f2 = {2'b00, a2, b2} * {2'b00, c2, d2};

  mul2x2_seq_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst8_n), .start(st[0]), .op_x(ox[0]), .op_y(oy[0]),
    .busy(busy8), .done(done8), .product(p8),
    .mul_a(a8), .mul_b(b8), .mul_c(c8), .mul_d(d8), .mul_f(f8)
  );
  mul2x2_seq_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .op_x(ox[1][3:0]), .op_y(oy[1][3:0]),
    .busy(busy4), .done(done4), .product(p4),
    .mul_a(a4), .mul_b(b4), .mul_c(c4), .mul_d(d4), .mul_f(f4)
  );
  mul2x2_seq_ctrl #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .op_x(ox[2][1:0]), .op_y(oy[2][1:0]),
    .busy(busy2), .done(done2), .product(p2),
    .mul_a(a2), .mul_b(b2), .mul_c(c2), .mul_d(d2), .mul_f(f2)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic fail(input string nm);
    n_total++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  exp_t        q [3][$];
  logic [15:0] held [3];
  logic        prev_done [3];
  logic        mon_en = 1'b0;

  // DD = digit pairs per operation for each instance
  function automatic int dd(input int k);
    return (k == 0) ? 16 : (k == 1) ? 4 : 1;
  endfunction

  function automatic logic [15:0] ref_mul(input int k, input logic [7:0] x, input logic [7:0] y);
    int w;
    longint m;
    w = (k == 0) ? 8 : (k == 1) ? 4 : 2;
    m = longint'(x % (1 << w)) * longint'(y % (1 << w));
    return 16'(m);
  endfunction

  task automatic monitor_one(input int k, input logic dn, input logic bz, input logic [15:0] pr);
    exp_t e;
    string tag;
    tag = $sformatf("w%0d", (k == 0) ? 8 : (k == 1) ? 4 : 2);
    if (dn) begin
      chk({tag, "_done_single_pulse"}, 32'(prev_done[k]), 32'd0);
      chk({tag, "_busy_in_done"}, 32'(bz), 32'd1);
      if (q[k].size() == 0) begin
        fail({tag, "_unexpected_done"});
      end else begin
        e = q[k].pop_front();
        chk({tag, "_product"}, 32'(pr), 32'(e.p));
        chk({tag, "_done_cycle"}, cyc, e.cyc);
        held[k] = e.p;
      end
    end else begin
      if (prev_done[k]) chk({tag, "_busy_after_done"}, 32'(bz), 32'd0);
      chk({tag, "_product_hold"}, 32'(pr), 32'(held[k]));
    end
    prev_done[k] = dn;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      monitor_one(0, done8, busy8, p8);
      monitor_one(1, done4, busy4, {8'd0, p4});
      monitor_one(2, done2, busy2, {12'd0, p2});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation; returns in the first IDLE cycle after done.
  task automatic run_op(input int k, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    st[k] = 1'b1;
    ox[k] = x;
    oy[k] = y;
    step();
    e.p = ref_mul(k, x, y);
    e.cyc = cyc + dd(k);
    q[k].push_back(e);
    st[k] = 1'b0;
    ox[k] = 8'($urandom);
    oy[k] = 8'($urandom);
    repeat (dd(k) + 1) step();
  endtask

  task automatic thread_w8();
    exp_t e;
    run_op(0, 8'hFF, 8'hFF);

    // Digit order: j (y digit) advances first
    st[0] = 1'b1; ox[0] = 8'h5A; oy[0] = 8'h3C;
    step();
    e.p = 16'h1518; e.cyc = cyc + 16; q[0].push_back(e);
    st[0] = 1'b0;
    chk("w8_run1_x_digit", 32'({a8, b8}), 32'd2);
    chk("w8_run1_y_digit", 32'({c8, d8}), 32'd0);
    step();
    chk("w8_run2_x_digit", 32'({a8, b8}), 32'd2);
    chk("w8_run2_y_digit", 32'({c8, d8}), 32'd3);
    repeat (16) step();

    // start held high; operands change mid-run
    st[0] = 1'b1; ox[0] = 8'h5A; oy[0] = 8'h3C;
    step();
    e.p = 16'h1518; e.cyc = cyc + 16; q[0].push_back(e);
    e.p = 16'h002A; e.cyc = cyc + 18 + 16; q[0].push_back(e);
    repeat (3) step();
    ox[0] = 8'd7; oy[0] = 8'd6;
    repeat (15) step();
    st[0] = 1'b0;
    repeat (17) step();

    // Reset during RUN cycle 5 aborts with no done
    st[0] = 1'b1; ox[0] = 8'h37; oy[0] = 8'h91;
    step();
    st[0] = 1'b0;
    repeat (4) step();
    rst8_req = 1'b1;
    step();
    rst8_req = 1'b0;
    held[0] = 16'd0;
    chk("w8_rst_busy", 32'(busy8), 32'd0);
    chk("w8_rst_done", 32'(done8), 32'd0);
    chk("w8_rst_product", 32'(p8), 32'd0);
    chk("w8_rst_mul", 32'({a8, b8, c8, d8}), 32'd0);
    repeat (20) step();
    run_op(0, 8'd2, 8'd3);

    for (int n = 0; n < 40; n++) begin
      run_op(0, 8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  task automatic thread_w4();
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        run_op(1, 8'(x), 8'(y));
  endtask

  task automatic thread_w2();
    exp_t e;
    st[2] = 1'b1; ox[2] = 8'd3; oy[2] = 8'd3;
    step();
    e.p = 16'd9; e.cyc = cyc + 1; q[2].push_back(e);
    st[2] = 1'b0;
    chk("w2_run_mul_bits", 32'({a2, b2, c2, d2}), 32'hF);
    repeat (2) step();
    for (int n = 0; n < 30; n++) begin
      run_op(2, 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 1)) step();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rst8_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      st[k] = 1'b0; ox[k] = 8'd0; oy[k] = 8'd0;
      held[k] = 16'd0; prev_done[k] = 1'b0;
    end
    repeat (3) step();
    chk("rst_busy", 32'({busy8, busy4, busy2}), 32'd0);
    chk("rst_done", 32'({done8, done4, done2}), 32'd0);
    chk("rst_product8", 32'(p8), 32'd0);
    chk("rst_product4", 32'(p4), 32'd0);
    chk("rst_product2", 32'(p2), 32'd0);
    chk("rst_mul", 32'({a8, b8, c8, d8, a4, b4, c4, d4, a2, b2, c2, d2}), 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    step();

    fork
      thread_w8();
      thread_w4();
      thread_w2();
    join

    begin
      int guard;
      guard = 0;
      while ((q[0].size() + q[1].size() + q[2].size()) != 0 && guard < 100) begin
        step();
        guard++;
      end
      if ((q[0].size() + q[1].size() + q[2].size()) != 0) fail("drain_timeout");
    end
    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
